// File: rtl/wrr_pkg.sv
// Shared definitions for the round-robin word register arbiter: FSM encoding,
// round-robin selection and a constant log2 helper.
package wrr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } wrr_state_e;

    // Selection result; sized for the largest supported requester count (8).
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_sel_t;

    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // First set request searching upward from ptr+1, wrapping modulo n.
    function automatic rr_sel_t rr_select(input logic [7:0] req,
                                          input logic [2:0] ptr,
                                          input int unsigned n);
        rr_sel_t     s;
        int unsigned idx;
        s = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i <= n && !s.found && req[idx[2:0]]) begin
                s.found = 1'b1;
                s.idx   = idx[2:0];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/word_register_arbiter_if.sv
// Request/data/acknowledge bundle between the requesters and the shared word
// register arbiter.
interface word_register_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int OWN_W = wrr_pkg::clog2(NUM_REQ);

    logic                     Clear_i;
    logic [NUM_REQ-1:0]       Req_i;
    logic [NUM_REQ*WIDTH-1:0] D_i;
    logic [NUM_REQ-1:0]       Ack_o;
    logic [WIDTH-1:0]         Q_o;
    logic                     Valid_o;
    logic                     Busy_o;
    logic [OWN_W-1:0]         Owner_o;

    modport master (
        output Clear_i, Req_i, D_i,
        input  Ack_o, Q_o, Valid_o, Busy_o, Owner_o
    );

    modport slave (
        input  Clear_i, Req_i, D_i,
        output Ack_o, Q_o, Valid_o, Busy_o, Owner_o
    );

endinterface

// File: rtl/WordRegister.sv
// Word register with clock enable and async active-low reset.
// Latency: 1 cycle from Enable_i to Q_o; no backpressure.
module WordRegister #(
    parameter int WIDTH = 16
) (
    input  logic             Reset_n_i,
    input  logic             Clk_i,
    input  logic             Enable_i,
    input  logic [WIDTH-1:0] D_i,
    output logic [WIDTH-1:0] Q_o
);

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            Q_o <= '0;
        end else if (Enable_i) begin
            Q_o <= D_i;
        end
    end

endmodule

// File: rtl/word_register_arbiter.sv
// Round-robin arbiter sharing one word register among NUM_REQ requesters.
// Latency 1 cycle request->Ack/Q_o; requests are held off (Busy_o) for HOLD_CYCLES after each write.
module word_register_arbiter
    import wrr_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    Reset_n_i,
    input  logic                    Clk_i,
    word_register_arbiter_if.slave  bus
);

    localparam int              OWN_W   = clog2(NUM_REQ);
    localparam logic [OWN_W-1:0] PTR_RST = OWN_W'(NUM_REQ - 1);

    wrr_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OWN_W-1:0]   ptr_q, ptr_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic               reg_en;
    logic [WIDTH-1:0]   reg_d;
    logic [7:0]         req_ext;
    rr_sel_t            sel;
    logic [OWN_W-1:0]   sel_idx;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = bus.Req_i;
        sel                    = rr_select(req_ext, 3'(ptr_q), NUM_REQ);
        sel_idx                = OWN_W'(sel.idx);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ack_d   = '0;
        reg_en  = 1'b0;
        reg_d   = bus.D_i[int'(sel_idx)*WIDTH +: WIDTH];

        if (bus.Clear_i) begin
            // Clear wins over any grant: load zero into the register.
            reg_en  = 1'b1;
            reg_d   = '0;
            state_d = ST_IDLE;
            cnt_d   = '0;
            ptr_d   = PTR_RST;
            owner_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel.found) begin
                        reg_en  = 1'b1;
                        ack_d   = NUM_REQ'(1) << sel_idx;
                        owner_d = sel_idx;
                        ptr_d   = sel_idx;
                        valid_d = 1'b1;
                        if (HOLD_CYCLES > 0) begin
                            cnt_d   = CNT_W'(HOLD_CYCLES);
                            busy_d  = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Leave at 1 so the counter can never wrap below zero.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= PTR_RST;
            owner_q <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    WordRegister #(
        .WIDTH (WIDTH)
    ) u_word_reg (
        .Reset_n_i (Reset_n_i),
        .Clk_i     (Clk_i),
        .Enable_i  (reg_en),
        .D_i       (reg_d),
        .Q_o       (bus.Q_o)
    );

    assign bus.Ack_o   = ack_q;
    assign bus.Valid_o = valid_q;
    assign bus.Busy_o  = busy_q;
    assign bus.Owner_o = owner_q;

endmodule

// File: tb/tb_word_register_arbiter.sv
// Directed bench: hold window of 2 on one instance, back-to-back grants on a second.
module tb_word_register_arbiter;

    logic        clk;
    logic        rst_n;
    logic [63:0] d_bus;
    int          checks;
    int          errors;

    typedef struct {
        logic        clr;
        logic [3:0]  req;
        logic [3:0]  ack;
        logic [15:0] q;
        logic        v;
        logic        b;
        logic [1:0]  o;
    } vec_t;

    vec_t tbl [25];

    word_register_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) if2 ();
    word_register_arbiter_if #(.NUM_REQ(4), .WIDTH(16)) if0 ();

    assign if2.D_i = d_bus;
    assign if0.D_i = d_bus;

    word_register_arbiter #(.NUM_REQ(4), .WIDTH(16), .HOLD_CYCLES(2), .CNT_W(8)) u_dut2 (
        .Reset_n_i (rst_n),
        .Clk_i     (clk),
        .bus       (if2.slave)
    );

    word_register_arbiter #(.NUM_REQ(4), .WIDTH(16), .HOLD_CYCLES(0), .CNT_W(8)) u_dut0 (
        .Reset_n_i (rst_n),
        .Clk_i     (clk),
        .bus       (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk2(input string nm, input vec_t e);
        chk({nm, " ack"},   32'(if2.Ack_o),   32'(e.ack));
        chk({nm, " q"},     32'(if2.Q_o),     32'(e.q));
        chk({nm, " valid"}, 32'(if2.Valid_o), 32'(e.v));
        chk({nm, " busy"},  32'(if2.Busy_o),  32'(e.b));
        chk({nm, " owner"}, 32'(if2.Owner_o), 32'(e.o));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic clr, input logic [3:0] req, input logic [3:0] ack,
                                input logic [15:0] q, input logic v, input logic b,
                                input logic [1:0] o);
        vec_t r;
        r.clr = clr; r.req = req; r.ack = ack; r.q = q; r.v = v; r.b = b; r.o = o;
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        if2.Clear_i = 1'b0; if2.Req_i = 4'h0;
        if0.Clear_i = 1'b0; if0.Req_i = 4'h0;
        d_bus = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

        // clr req ack q valid busy owner
        tbl[0]  = mk(1'b1, 4'hF, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd0);
        tbl[1]  = mk(1'b0, 4'hF, 4'h1, 16'hA000, 1'b1, 1'b1, 2'd0);
        tbl[2]  = mk(1'b0, 4'hF, 4'h0, 16'hA000, 1'b1, 1'b1, 2'd0);
        tbl[3]  = mk(1'b0, 4'hF, 4'h0, 16'hA000, 1'b1, 1'b0, 2'd0);
        tbl[4]  = mk(1'b0, 4'hF, 4'h2, 16'hA001, 1'b1, 1'b1, 2'd1);
        tbl[5]  = mk(1'b0, 4'hF, 4'h0, 16'hA001, 1'b1, 1'b1, 2'd1);
        tbl[6]  = mk(1'b0, 4'hF, 4'h0, 16'hA001, 1'b1, 1'b0, 2'd1);
        tbl[7]  = mk(1'b0, 4'hF, 4'h4, 16'hA002, 1'b1, 1'b1, 2'd2);
        tbl[8]  = mk(1'b0, 4'hF, 4'h0, 16'hA002, 1'b1, 1'b1, 2'd2);
        tbl[9]  = mk(1'b0, 4'hF, 4'h0, 16'hA002, 1'b1, 1'b0, 2'd2);
        tbl[10] = mk(1'b0, 4'hF, 4'h8, 16'hA003, 1'b1, 1'b1, 2'd3);
        tbl[11] = mk(1'b0, 4'hF, 4'h0, 16'hA003, 1'b1, 1'b1, 2'd3);
        tbl[12] = mk(1'b0, 4'hF, 4'h0, 16'hA003, 1'b1, 1'b0, 2'd3);
        tbl[13] = mk(1'b0, 4'hF, 4'h1, 16'hA000, 1'b1, 1'b1, 2'd0);
        tbl[14] = mk(1'b0, 4'h4, 4'h0, 16'hA000, 1'b1, 1'b1, 2'd0);
        tbl[15] = mk(1'b0, 4'h4, 4'h0, 16'hA000, 1'b1, 1'b0, 2'd0);
        tbl[16] = mk(1'b0, 4'h4, 4'h4, 16'hA002, 1'b1, 1'b1, 2'd2);
        tbl[17] = mk(1'b0, 4'h0, 4'h0, 16'hA002, 1'b1, 1'b1, 2'd2);
        tbl[18] = mk(1'b0, 4'h0, 4'h0, 16'hA002, 1'b1, 1'b0, 2'd2);
        tbl[19] = mk(1'b1, 4'h8, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd0);
        tbl[20] = mk(1'b0, 4'h9, 4'h1, 16'hA000, 1'b1, 1'b1, 2'd0);
        tbl[21] = mk(1'b1, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd0);
        tbl[22] = mk(1'b0, 4'h8, 4'h8, 16'hA003, 1'b1, 1'b1, 2'd3);
        tbl[23] = mk(1'b0, 4'h0, 4'h0, 16'hA003, 1'b1, 1'b1, 2'd3);
        tbl[24] = mk(1'b0, 4'h0, 4'h0, 16'hA003, 1'b1, 1'b0, 2'd3);

        // Reset state while reset is held across clock edges.
        step();
        step();
        chk2("reset", mk(1'b0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd0));
        chk("reset0 ack", 32'(if0.Ack_o), 32'h0);
        chk("reset0 valid", 32'(if0.Valid_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin, hold window, requests during HOLD, clear cases.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if2.Clear_i = tbl[i].clr;
            if2.Req_i   = tbl[i].req;
            step();
            chk2($sformatf("row%0d", i), tbl[i]);
        end

        // Single write from requester 0 with a distinct data word.
        @(negedge clk);
        if2.Clear_i = 1'b0;
        d_bus[15:0] = 16'h1234;
        if2.Req_i = 4'h1;
        step();
        chk2("w1234 grant", mk(1'b0, 4'h0, 4'h1, 16'h1234, 1'b1, 1'b1, 2'd0));
        @(negedge clk);
        if2.Req_i = 4'h0;
        step();
        chk2("w1234 hold", mk(1'b0, 4'h0, 4'h0, 16'h1234, 1'b1, 1'b1, 2'd0));
        step();
        chk2("w1234 free", mk(1'b0, 4'h0, 4'h0, 16'h1234, 1'b1, 1'b0, 2'd0));
        d_bus[15:0] = 16'hA000;

        // No hold window: two requesters alternate every cycle.
        @(negedge clk);
        if0.Req_i = 4'h3;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("b2b%0d ack", i), 32'(if0.Ack_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("b2b%0d q", i), 32'(if0.Q_o), (i % 2 == 0) ? 32'hA000 : 32'hA001);
            chk($sformatf("b2b%0d busy", i), 32'(if0.Busy_o), 32'h0);
            chk($sformatf("b2b%0d valid", i), 32'(if0.Valid_o), 32'h1);
        end
        @(negedge clk);
        if0.Req_i = 4'h0;

        // Reset asserted while the hold counter is at 1.
        @(negedge clk);
        if2.Req_i = 4'h4;
        step();
        chk2("rst grant", mk(1'b0, 4'h0, 4'h4, 16'hA002, 1'b1, 1'b1, 2'd2));
        @(negedge clk);
        if2.Req_i = 4'h0;
        step();
        chk2("rst hold", mk(1'b0, 4'h0, 4'h0, 16'hA002, 1'b1, 1'b1, 2'd2));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk2("rst async", mk(1'b0, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd0));
        @(negedge clk);
        rst_n = 1'b1;
        if2.Req_i = 4'h2;
        step();
        chk2("rst regrant", mk(1'b0, 4'h0, 4'h2, 16'hA001, 1'b1, 1'b1, 2'd1));
        @(negedge clk);
        if2.Req_i = 4'h0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
